// File: rtl/fp_convert_result_buffer.sv
// fp_convert_result_buffer
// Registered two-entry skid buffer placed after the float format converter.
// Holds each converted float with its {invalid, overflow, underflow} flags and
// presents them on a valid/ready interface. Also keeps a sticky exception
// status register.
// Optional build macro FP_FLAG_COUNTERS_EN adds the COUNTER_WIDTH parameter and
// three saturating per-flag event counters.
//
//   state     | meaning
//   ----------+---------------------------------------------
//   ST_EMPTY  | nothing held, out_valid low
//   ST_ONE    | head register valid, skid register free
//   ST_FULL   | head and skid both valid, in_ready low
module fp_convert_result_buffer #(
  parameter int EXPONENT_WIDTH = 11,
  parameter int MANTISSA_WIDTH = 52
`ifdef FP_FLAG_COUNTERS_EN
  , parameter int COUNTER_WIDTH = 16
`endif
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid_i,
  output logic                                   in_ready_o,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] in_data_i,
  input  logic                                   in_underflow_i,
  input  logic                                   in_overflow_i,
  input  logic                                   in_invalid_i,
  output logic                                   out_valid_o,
  input  logic                                   out_ready_i,
  output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] out_data_o,
  output logic [2:0]                             out_flags_o,
  output logic [1:0]                             occupancy_o,
  input  logic                                   sticky_clear_i,
`ifdef FP_FLAG_COUNTERS_EN
  output logic [COUNTER_WIDTH-1:0]               count_underflow_o,
  output logic [COUNTER_WIDTH-1:0]               count_overflow_o,
  output logic [COUNTER_WIDTH-1:0]               count_invalid_o,
`endif
  output logic [2:0]                             sticky_flags_o
);

  localparam int DATA_W  = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int ENTRY_W = DATA_W + 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [ENTRY_W-1:0]   head_q, head_d;
  logic [ENTRY_W-1:0]   skid_q, skid_d;
  logic                 in_ready_q, in_ready_d;
  logic [2:0]           sticky_q, sticky_d;

  logic [2:0]           in_flags;
  logic [ENTRY_W-1:0]   in_entry;
  logic                 push;
  logic                 pop;

  // Flags travel above the data bits so an entry is moved as one word.
  assign in_flags = {in_invalid_i, in_overflow_i, in_underflow_i};
  assign in_entry = {in_flags, in_data_i};
  assign push     = in_valid_i && in_ready_q;
  assign pop      = (state_q != ST_EMPTY) && out_ready_i;

  // Next occupancy and entry movement; the head only changes when it is
  // popped or loaded from empty, which keeps it stable under back-pressure.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      ST_EMPTY: begin
        if (push) begin
          head_d  = in_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (push && pop) begin
          head_d = in_entry;
        end else if (push) begin
          skid_d  = in_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          head_d  = skid_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    in_ready_d = (state_d != ST_FULL);
  end

  // Sticky status: clear first, then OR in the accepted flags so a new event
  // arriving with the clear survives.
  always_comb begin
    sticky_d = sticky_clear_i ? 3'b000 : sticky_q;
    if (push) begin
      sticky_d = sticky_d | in_flags;
    end
  end

  // State, storage and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
      sticky_q   <= 3'b000;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
      sticky_q   <= sticky_d;
    end
  end

  assign in_ready_o     = in_ready_q;
  assign out_valid_o    = (state_q != ST_EMPTY);
  assign out_data_o     = head_q[DATA_W-1:0];
  assign out_flags_o    = head_q[ENTRY_W-1:DATA_W];
  assign occupancy_o    = state_q;
  assign sticky_flags_o = sticky_q;

`ifdef FP_FLAG_COUNTERS_EN
  localparam logic [COUNTER_WIDTH-1:0] CNT_ONE = {{(COUNTER_WIDTH-1){1'b0}}, 1'b1};

  logic [COUNTER_WIDTH-1:0] cnt_q [3];
  logic [COUNTER_WIDTH-1:0] cnt_d [3];

  // Per-flag counters: clear, then saturating increment on an accepted event.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      cnt_d[i] = sticky_clear_i ? '0 : cnt_q[i];
      if (push && in_flags[i] && (cnt_d[i] != '1)) begin
        cnt_d[i] = cnt_d[i] + CNT_ONE;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign count_underflow_o = cnt_q[0];
  assign count_overflow_o  = cnt_q[1];
  assign count_invalid_o   = cnt_q[2];
`endif

endmodule

// File: tb/tb_fp_convert_result_buffer.sv
// Directed and randomized bench for fp_convert_result_buffer, checked against
// a queue-based reference model of the buffer and its sticky status.
module tb_fp_convert_result_buffer;

  localparam int CW = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_underflow;
  logic        in_overflow;
  logic        in_invalid;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic [2:0]  out_flags;
  logic [1:0]  occupancy;
  logic        sticky_clear;
  logic [2:0]  sticky_flags;
`ifdef FP_FLAG_COUNTERS_EN
  logic [CW-1:0] count_underflow;
  logic [CW-1:0] count_overflow;
  logic [CW-1:0] count_invalid;
`endif

  int errors = 0;
  int checks = 0;

  // Reference model: queue of {flags, data} entries.
  logic [66:0] mq[$];
  logic [66:0] last_head;
  logic [2:0]  m_sticky;
  int          m_cnt[3];

  always #5 clk = ~clk;

`ifdef FP_FLAG_COUNTERS_EN
  fp_convert_result_buffer #(.EXPONENT_WIDTH(11), .MANTISSA_WIDTH(52), .COUNTER_WIDTH(CW)) dut (
`else
  fp_convert_result_buffer #(.EXPONENT_WIDTH(11), .MANTISSA_WIDTH(52)) dut (
`endif
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_data_i      (in_data),
    .in_underflow_i (in_underflow),
    .in_overflow_i  (in_overflow),
    .in_invalid_i   (in_invalid),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_data_o     (out_data),
    .out_flags_o    (out_flags),
    .occupancy_o    (occupancy),
    .sticky_clear_i (sticky_clear),
`ifdef FP_FLAG_COUNTERS_EN
    .count_underflow_o (count_underflow),
    .count_overflow_o  (count_overflow),
    .count_invalid_o   (count_invalid),
`endif
    .sticky_flags_o (sticky_flags)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    last_head = '0;
    m_sticky  = 3'b000;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endtask

  task automatic check_all(input string where);
    logic [66:0] head;
    head = (mq.size() > 0) ? mq[0] : last_head;
    chk({where, ":out_valid"}, 64'(out_valid), 64'(mq.size() > 0));
    chk({where, ":occupancy"}, 64'(occupancy), 64'(mq.size()));
    chk({where, ":in_ready"},  64'(in_ready),  64'(mq.size() < 2));
    chk({where, ":out_data"},  out_data,       head[63:0]);
    chk({where, ":out_flags"}, 64'(out_flags), 64'(head[66:64]));
    chk({where, ":sticky"},    64'(sticky_flags), 64'(m_sticky));
`ifdef FP_FLAG_COUNTERS_EN
    chk({where, ":cnt_unf"}, 64'(count_underflow), 64'(m_cnt[0]));
    chk({where, ":cnt_ovf"}, 64'(count_overflow),  64'(m_cnt[1]));
    chk({where, ":cnt_inv"}, 64'(count_invalid),   64'(m_cnt[2]));
`endif
  endtask

  // One clock: drive at negedge, update model at posedge, check next negedge.
  task automatic cycle(input string where, input logic iv, input logic [63:0] d,
                       input logic [2:0] f, input logic ordy, input logic clr);
    bit do_push, do_pop;
    int maxc;
    in_valid     = iv;
    in_data      = d;
    {in_invalid, in_overflow, in_underflow} = f;
    out_ready    = ordy;
    sticky_clear = clr;
    do_push = iv && (mq.size() < 2);
    do_pop  = (mq.size() > 0) && ordy;
    @(posedge clk);
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back({f, d});
    if (mq.size() > 0) last_head = mq[0];
    if (clr) m_sticky = 3'b000;
    if (do_push) m_sticky = m_sticky | f;
    maxc = (1 << CW) - 1;
    for (int i = 0; i < 3; i++) begin
      if (clr) m_cnt[i] = 0;
      if (do_push && f[i] && m_cnt[i] < maxc) m_cnt[i] = m_cnt[i] + 1;
    end
    @(negedge clk);
    check_all(where);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; in_data = '0; in_underflow = 1'b0; in_overflow = 1'b0;
    in_invalid = 1'b0; out_ready = 1'b0; sticky_clear = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;

    // Single pass
    cycle("single_push", 1'b1, 64'h3FF0000000000000, 3'b000, 1'b1, 1'b0);
    chk("single_data", out_data, 64'h3FF0000000000000);
    chk("single_valid", 64'(out_valid), 64'd1);
    cycle("single_pop", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);
    chk("single_occ_after_pop", 64'(occupancy), 64'd0);

    // Back-pressure
    cycle("bp_push1", 1'b1, 64'h3FF0000000000000, 3'b000, 1'b0, 1'b0);
    cycle("bp_push2", 1'b1, 64'h4000000000000000, 3'b000, 1'b0, 1'b0);
    chk("bp_full_occ", 64'(occupancy), 64'd2);
    chk("bp_full_ready", 64'(in_ready), 64'd0);
    cycle("bp_push3", 1'b1, 64'h4008000000000000, 3'b111, 1'b0, 1'b0);
    chk("bp_hold_data", out_data, 64'h3FF0000000000000);
    cycle("bp_pop1", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);
    chk("bp_pop1_data", out_data, 64'h4000000000000000);
    chk("bp_pop1_ready", 64'(in_ready), 64'd1);
    cycle("bp_pop2", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);
    chk("bp_empty_valid", 64'(out_valid), 64'd0);

    // Sticky flags
    cycle("st_clr", 1'b0, 64'h0, 3'b000, 1'b1, 1'b1);
    cycle("st_p1", 1'b1, 64'h1, 3'b001, 1'b1, 1'b0);
    cycle("st_p2", 1'b1, 64'h2, 3'b100, 1'b1, 1'b0);
    chk("sticky_101", 64'(sticky_flags), 64'h5);
    cycle("st_p3", 1'b1, 64'h3, 3'b010, 1'b1, 1'b1);
    chk("sticky_010", 64'(sticky_flags), 64'h2);
    cycle("st_drain", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);

    // Streaming
    for (int i = 0; i < 100; i++) begin
      cycle("stream", 1'b1, 64'(i + 1000), 3'b000, 1'b1, 1'b0);
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_data", out_data, 64'(i + 1000));
    end
    cycle("stream_drain", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);

`ifdef FP_FLAG_COUNTERS_EN
    cycle("cnt_clr", 1'b0, 64'h0, 3'b000, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++)
      cycle("cnt_ovf", 1'b1, 64'(i), 3'b010, 1'b1, 1'b0);
    chk("cnt_saturated", 64'(count_overflow), 64'd3);
    cycle("cnt_clr_evt", 1'b1, 64'h9, 3'b010, 1'b1, 1'b1);
    chk("cnt_clr_evt_one", 64'(count_overflow), 64'd1);
    cycle("cnt_drain", 1'b0, 64'h0, 3'b000, 1'b1, 1'b0);
`endif

    // Reset mid-operation
    cycle("rst_fill1", 1'b1, 64'hAAAA, 3'b101, 1'b0, 1'b0);
    cycle("rst_fill2", 1'b1, 64'hBBBB, 3'b011, 1'b0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_async_valid", 64'(out_valid), 64'd0);
    chk("rst_async_occ", 64'(occupancy), 64'd0);
    chk("rst_async_sticky", 64'(sticky_flags), 64'd0);
    chk("rst_async_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    check_all("after_reset");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cycle("rand", 1'($urandom_range(0, 1)), {$urandom, $urandom},
            3'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 7) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
